// File: rtl/pcint_pkg.sv
// pcint_pkg: register map, FSM types and priming length shared by pcint_ctrl.
// PCINT_SYNC_EN selects the 2-flop input synchronizer and a 2-cycle prime.
`ifndef PCINT_BASE
`define PCINT_BASE 32'h4000_1000
`endif
`ifndef PCINT_PCMSK
`define PCINT_PCMSK 4'h0
`endif
`ifndef PCINT_PCICR
`define PCINT_PCICR 4'h4
`endif
`ifndef PCINT_PCIFR
`define PCINT_PCIFR 4'h8
`endif

package pcint_pkg;
  localparam logic [31:0] PCINT_BASE_ADDR = `PCINT_BASE;
  localparam logic [3:0] OFF_PCMSK = `PCINT_PCMSK;
  localparam logic [3:0] OFF_PCICR = `PCINT_PCICR;
  localparam logic [3:0] OFF_PCIFR = `PCINT_PCIFR;
`ifdef PCINT_SYNC_EN
  localparam int PRIME_CYCLES = 2;
`else
  localparam int PRIME_CYCLES = 1;
`endif
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
  typedef enum logic {PRIME, ARMED} prime_state_t;
  function automatic logic is_reg_off(input logic [3:0] off);
    return off == OFF_PCMSK || off == OFF_PCICR || off == OFF_PCIFR;
  endfunction
endpackage

// File: rtl/pcint_edge_detect.sv
// pcint_edge_detect: pin synchronizer, prev register and priming FSM producing per-pin change pulses.
// PCINT_SYNC_EN adds a 2-flop synchronizer; otherwise pin_in is registered once.
module pcint_edge_detect import pcint_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] change
);
  logic [WIDTH-1:0] r_pin_s, r_prev, w_stage_in;
  logic [1:0] r_cnt, w_cnt_next;
  prime_state_t r_state, w_state_next;
`ifdef PCINT_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_pin_s <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_pin_s <= r_sync1;
    end
  end
  assign w_stage_in = r_sync1;
`else
  always_ff @(posedge clk) begin
    if (rst) r_pin_s <= '0;
    else r_pin_s <= pin_in;
  end
  assign w_stage_in = pin_in;
`endif
  // While priming, prev tracks the value entering pin_s so the two agree on arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_state <= PRIME;
      r_cnt   <= '0;
    end else begin
      r_prev  <= (r_state == PRIME) ? w_stage_in : r_pin_s;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == PRIME) begin
      w_cnt_next   = r_cnt + 2'd1;
      w_state_next = (r_cnt == 2'(PRIME_CYCLES - 1)) ? ARMED : PRIME;
    end
  end
  assign change = (r_state == ARMED) ? (r_pin_s ^ r_prev) : '0;
endmodule

// File: rtl/pcint_ctrl.sv
// pcint_ctrl: pin-change interrupt controller with PCMSK/PCICR/PCIFR on a valid/ready bus.
// PCINT_SYNC_EN (in pcint_edge_detect) selects the synchronized input path.
module pcint_ctrl import pcint_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = PCINT_BASE_ADDR,
  parameter int          WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  input  logic [WIDTH-1:0] pin_in,
  output logic             irq
);
  bus_state_t r_bus, w_bus_next;
  logic [WIDTH-1:0] r_pcmsk, w_change;
  logic [7:0] r_rdata, w_rd_val;
  logic r_pcie, r_pcif;
  logic w_hit, w_commit, w_wr, w_rd, w_pcif_set, w_pcif_clr, w_unused;
  pcint_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .pin_in (pin_in),
    .change (w_change)
  );
  always_comb begin
    w_hit      = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4] && is_reg_off(mem_addr[3:0]);
    w_commit   = r_bus == BUS_IDLE && w_hit;
    w_wr       = w_commit && mem_wstrb[0];
    w_rd       = w_commit && mem_wstrb == 4'b0;
    w_pcif_set = |(w_change & r_pcmsk);
    w_pcif_clr = w_wr && mem_addr[3:0] == OFF_PCIFR && mem_wdata[0];
    w_rd_val   = mem_addr[3:0] == OFF_PCMSK ? 8'(r_pcmsk) :
                 mem_addr[3:0] == OFF_PCICR ? {7'b0, r_pcie} : {7'b0, r_pcif};
    w_bus_next = w_commit ? BUS_ACK : (r_bus == BUS_ACK && !mem_valid) ? BUS_IDLE : r_bus;
  end
  // A new masked change outranks a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus   <= BUS_IDLE;
      r_pcmsk <= '0;
      r_pcie  <= 1'b0;
      r_pcif  <= 1'b0;
      r_rdata <= 8'h0;
    end else begin
      r_bus  <= w_bus_next;
      r_pcif <= w_pcif_set | (r_pcif & ~w_pcif_clr);
      if (w_wr && mem_addr[3:0] == OFF_PCMSK) r_pcmsk <= mem_wdata[WIDTH-1:0];
      if (w_wr && mem_addr[3:0] == OFF_PCICR) r_pcie <= mem_wdata[0];
      if (w_commit) r_rdata <= w_rd ? w_rd_val : 8'h0;
    end
  end
  assign mem_ready = r_bus == BUS_ACK;
  assign mem_rdata = mem_ready ? {24'b0, r_rdata} : 32'b0;
  assign irq       = r_pcie & r_pcif;
  assign w_unused  = ^mem_wdata[31:WIDTH];
endmodule

// File: tb/tb_pcint_ctrl.sv
// tb_pcint_ctrl: directed self-checking bench for pcint_ctrl.
module tb_pcint_ctrl;
  import pcint_pkg::*;
`ifdef PCINT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] A_MSK = PCINT_BASE_ADDR;
  localparam logic [31:0] A_CR  = PCINT_BASE_ADDR + 32'h4;
  localparam logic [31:0] A_FR  = PCINT_BASE_ADDR + 32'h8;
  localparam logic [31:0] A_BAD = PCINT_BASE_ADDR + 32'hC;
  logic clk = 1'b0, rst = 1'b1, mem_valid = 1'b0, mem_ready, irq;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, rd;
  logic [3:0] mem_wstrb = '0;
  logic [7:0] pin_in = 8'hFF;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  pcint_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pin_in    (pin_in),
    .irq       (irq)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    mem_wstrb = strb;
  endtask
  task automatic xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata);
    int n = 0;
    drive(addr, data, strb);
    do begin
      tick();
      n++;
    end while (!mem_ready && n < 8);
    check("bus_ack", 32'(mem_ready), 32'd1);
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    tick();
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    xfer(addr, data, 4'h1, d);
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    xfer(addr, 32'h0, 4'h0, d);
    check(tag, d, exp);
  endtask
  initial begin
    repeat (20) tick();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("prime_irq", 32'(irq), 32'd0);
    rd_chk("rst_pcifr", A_FR, 32'h00);
    rd_chk("rst_pcmsk", A_MSK, 32'h00);
    rd_chk("rst_pcicr", A_CR, 32'h00);
    wr(A_MSK, 32'h0F);
    wr(A_CR, 32'h01);
    rd_chk("pcmsk_0f", A_MSK, 32'h0F);
    rd_chk("pcicr_01", A_CR, 32'h01);
    pin_in = 8'hDF;
    repeat (6) tick();
    check("masked_irq", 32'(irq), 32'd0);
    rd_chk("masked_pcifr", A_FR, 32'h00);
    pin_in = 8'hDB;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("latency_irq", 32'(irq), 32'(k == LAT));
    end
    rd_chk("flag_pcifr", A_FR, 32'h01);
    wr(A_FR, 32'h00);
    rd_chk("w0_pcifr", A_FR, 32'h01);
    check("w0_irq", 32'(irq), 32'd1);
    drive(A_FR, 32'h01, 4'h1);
    tick();
    check("clr_ready", 32'(mem_ready), 32'd1);
    check("clr_irq", 32'(irq), 32'd0);
    mem_valid = 1'b0;
    tick();
    rd_chk("clr_pcifr", A_FR, 32'h00);
    pin_in = 8'hDA;
    repeat (LAT - 1) tick();
    drive(A_FR, 32'h01, 4'h1);
    tick();
    check("race_ready", 32'(mem_ready), 32'd1);
    check("race_irq", 32'(irq), 32'd1);
    mem_valid = 1'b0;
    tick();
    rd_chk("race_pcifr", A_FR, 32'h01);
    wr(A_FR, 32'h01);
    rd_chk("race_clr", A_FR, 32'h00);
    drive(A_MSK, 32'hA5, 4'h1);
    check("hold_pre", 32'(mem_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready", 32'(mem_ready), 32'd1);
      if (i == 1) mem_wdata = 32'h5A;
    end
    mem_valid = 1'b0;
    tick();
    check("hold_fall", 32'(mem_ready), 32'd0);
    rd_chk("hold_pcmsk", A_MSK, 32'hA5);
    drive(A_BAD, 32'hFF, 4'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nohit_ready", 32'(mem_ready), 32'd0);
      check("nohit_rdata", mem_rdata, 32'd0);
    end
    mem_valid = 1'b0;
    tick();
    rd_chk("nohit_pcmsk", A_MSK, 32'hA5);
    pin_in = 8'hDE;
    repeat (LAT + 1) tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    drive(A_MSK, 32'h0, 4'h0);
    tick();
    check("ack_ready", 32'(mem_ready), 32'd1);
    check("ack_rdata", mem_rdata, 32'hA5);
    rst = 1'b1;
    tick();
    check("rst_ack_ready", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_irq", 32'(irq), 32'd0);
    rd_chk("post_pcmsk", A_MSK, 32'h00);
    rd_chk("post_pcicr", A_CR, 32'h00);
    rd_chk("post_pcifr", A_FR, 32'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
